// File: rtl/key_event_array.sv
`default_nettype none
// ============================================================================
// Module      : key_event_array
// Description : Multi-channel key front end. Each of NUM_KEYS channels
//               synchronises and debounces one mechanical key input and
//               derives press / release / long-press / auto-repeat pulses
//               plus a per-key toggle bit.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_KEYS    number of independent key channels
//   CNT_W       width of the debounce and hold counters
//   MAX_CNT     debounce time in clock cycles (2 .. 2^CNT_W-1)
//   LONG_CNT    cycles from press pulse to long-press pulse (1 .. 2^CNT_W-1)
//   REPEAT_CNT  auto-repeat period after long press, 0 disables repeat
//   ACTIVE_LOW  1: pin reads 0 when pressed, 0: pin reads 1 when pressed
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   key_in       in   [NUM_KEYS] raw asynchronous key pins
//   key_state    out  [NUM_KEYS] debounced level, 1 = pressed
//   press        out  [NUM_KEYS] one-cycle pulse on debounced press
//   key_release  out  [NUM_KEYS] one-cycle pulse on debounced release
//   long_press   out  [NUM_KEYS] one-cycle pulse after LONG_CNT cycles held
//   key_repeat   out  [NUM_KEYS] pulse every REPEAT_CNT cycles after long press
//   toggle_out   out  [NUM_KEYS] flips on every press
// ============================================================================
module key_event_array #(
  parameter int                NUM_KEYS   = 4,
  parameter int                CNT_W      = 20,
  parameter logic [CNT_W-1:0]  MAX_CNT    = 20'd1_000_000,
  parameter logic [CNT_W-1:0]  LONG_CNT   = 20'd500_000,
  parameter logic [CNT_W-1:0]  REPEAT_CNT = 20'd100_000,
  parameter bit                ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] long_press,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic [NUM_KEYS-1:0] toggle_out
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO    = '0;
  localparam logic [CNT_W-1:0] MAX_M1  = MAX_CNT - ONE;
  localparam logic [CNT_W-1:0] LONG_M1 = LONG_CNT - ONE;
  localparam logic [CNT_W-1:0] REP_M1  = REPEAT_CNT - ONE;
  // Pin level of a released key; the synchronizer loads this on reset so a
  // key held through reset is seen as a fresh press, never as a release.
  localparam logic             REL_LVL = ACTIVE_LOW;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HELD = 1'b1
  } hold_state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key

    logic             sync1;
    logic             sync2;
    logic             raw;
    logic             level;
    logic [CNT_W-1:0] dcnt;
    logic             flip;
    logic             rise;
    logic             fall;
    logic             press_r;
    logic             release_r;
    logic             toggle_r;

    hold_state_t      state;
    hold_state_t      state_nx;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hcnt_nx;
    logic             long_done;
    logic             long_done_nx;
    logic             long_r;
    logic             long_nx;
    logic             rep_r;
    logic             rep_nx;

    // ------------------------------------------------------------------
    // Two-flop synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1 <= REL_LVL;
        sync2 <= REL_LVL;
      end else begin
        sync1 <= key_in[i];
        sync2 <= sync1;
      end
    end

    // Normalise polarity so that raw == 1 means pressed.
    assign raw  = sync2 ^ ACTIVE_LOW;

    // The debounced level flips only after raw has disagreed with it for
    // MAX_CNT consecutive cycles; any agreement restarts the count.
    assign flip = (raw != level) && (dcnt == MAX_M1);
    assign rise = flip && !level;
    assign fall = flip && level;

    // ------------------------------------------------------------------
    // Debounce counter, debounced level, edge pulses and toggle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
      if (rst) begin
        dcnt      <= ZERO;
        level     <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        toggle_r  <= 1'b0;
      end else begin
        press_r   <= rise;
        release_r <= fall;
        if (rise) begin
          toggle_r <= ~toggle_r;
        end
        if (raw == level) begin
          dcnt <= ZERO;
        end else if (flip) begin
          level <= ~level;
          dcnt  <= ZERO;
        end else begin
          dcnt <= dcnt + ONE;
        end
      end
    end

    // ------------------------------------------------------------------
    // Hold tracking FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= IDLE;
        hcnt      <= ZERO;
        long_done <= 1'b0;
        long_r    <= 1'b0;
        rep_r     <= 1'b0;
      end else begin
        state     <= state_nx;
        hcnt      <= hcnt_nx;
        long_done <= long_done_nx;
        long_r    <= long_nx;
        rep_r     <= rep_nx;
      end
    end

    // ------------------------------------------------------------------
    // Hold tracking FSM: next state and pulse decode
    // The FSM enters HELD on the same edge that raises press, so hcnt is 0
    // in the press cycle and the long pulse is registered on the edge where
    // hcnt reaches LONG_CNT-1, landing exactly LONG_CNT cycles after press.
    // A release checked first suppresses a coinciding long/repeat pulse.
    // ------------------------------------------------------------------
    always_comb begin
      state_nx     = state;
      hcnt_nx      = hcnt;
      long_done_nx = long_done;
      long_nx      = 1'b0;
      rep_nx       = 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state_nx     = HELD;
            hcnt_nx      = ZERO;
            long_done_nx = 1'b0;
          end
        end
        HELD: begin
          if (fall) begin
            state_nx     = IDLE;
            hcnt_nx      = ZERO;
            long_done_nx = 1'b0;
          end else if (!long_done) begin
            if (hcnt == LONG_M1) begin
              long_nx      = 1'b1;
              long_done_nx = 1'b1;
              hcnt_nx      = ZERO;
            end else begin
              hcnt_nx = hcnt + ONE;
            end
          end else if (REPEAT_CNT == ZERO) begin
            // Repeat disabled: count on but stop at all-ones.
            if (hcnt != '1) begin
              hcnt_nx = hcnt + ONE;
            end
          end else if (hcnt == REP_M1) begin
            rep_nx  = 1'b1;
            hcnt_nx = ZERO;
          end else begin
            hcnt_nx = hcnt + ONE;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end

    assign key_state[i]   = level;
    assign press[i]       = press_r;
    assign key_release[i] = release_r;
    assign long_press[i]  = long_r;
    assign key_repeat[i]  = rep_r;
    assign toggle_out[i]  = toggle_r;

  end : g_key

endmodule
`default_nettype wire
